alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ROUND_ROBIN, default 1, 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  block accepts requester N's operation this cycle.
REQ-006 reqN_x, reqN_y  input  32 each  operands of requester N.
REQ-007 reqN_funct3  input  3  ALU operation select of requester N.
REQ-008 reqN_funct7  input  7  ALU operation modifier of requester N (0 = ADD/SRL, nonzero = SUB/SRA).
REQ-009 rspN_valid  output  1  result for requester N available.
REQ-010 rspN_data  output  32  result for requester N.
REQ-011 rspN_ready  input  1  requester N consumes the result.
REQ-012 alu_x, alu_y  output  32 each  operands driven to the shared ALU.
REQ-013 alu_funct3  output  3, alu_funct7  output  7  operation driven to the shared ALU.
REQ-014 alu_out  input  32  combinational result from the shared ALU.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP; transitions IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE on response handshake.
REQ-017 reqN_ready is combinational, high only in IDLE and only for the granted requester; at most one reqN_ready high in any cycle.
REQ-018 Grant in IDLE: single valid requester wins; both valid with ROUND_ROBIN=1 -> requester not served last (last_grant register); ROUND_ROBIN=0 -> requester 0.
REQ-019 Accept = reqN_valid && reqN_ready; on accept x, y, funct3, funct7 and grant index are registered.
REQ-020 Requester deasserting valid before accept is legal; no grant and no last_grant update result.
REQ-021 alu_* outputs come directly from the operand registers, stable throughout EXEC and RESP, holding last values in IDLE.
REQ-022 At the end of the EXEC cycle, alu_out is captured into a 32-bit result register.
REQ-023 In RESP, rspG_valid=1 for granted requester G only, rspG_data = result register; the other rsp_valid is 0.
REQ-024 rspG_valid and rspG_data hold stable until rspG_ready; handshake moves to IDLE and sets last_grant=G.
REQ-025 Latency: accept at cycle T -> rsp_valid first high at T+2; minimum issue interval 3 cycles; no accept during RESP handshake cycle.
REQ-026 rspN_data is driven with the result register for both N; only rsp_valid qualifies it.
REQ-027 funct3/funct7 are passed through uninterpreted; no width change on any operand or result.

Reset
REQ-028 On rst: state IDLE, operand registers, funct fields and result register = 0, last_grant = 1 (requester 0 wins first tie), all rsp_valid = 0, busy = 0.
REQ-029 rst in EXEC or RESP aborts the operation; no response is ever issued for it.
REQ-030 rst has priority over any simultaneous accept or response handshake.

Verification
REQ-031 req0 x=5, y=3, f3=0, f7=0 accepted at T -> rsp0_valid at T+2, rsp0_data=8, rsp1_valid=0.
REQ-032 req0 x=3, y=5, f3=0, f7=0x20 -> rsp0_data=0xFFFFFFFE.
REQ-033 After reset, both valid continuously, ROUND_ROBIN=1, rsp_ready=1 -> grants 0,1,0,1 over four operations, each 3 cycles apart.
REQ-034 ROUND_ROBIN=0, both valid continuously -> req1_ready never high while req0_valid=1.
REQ-035 rsp0_ready held low 5 cycles in RESP -> rsp0_valid, rsp0_data, alu_* stable, both req_ready=0, busy=1.
REQ-036 rst pulsed in EXEC -> next cycle busy=0, all rsp_valid=0, alu_x=alu_y=0, no response follows.

Source files
------------

// File: rtl/alu_arbiter.sv
// Purpose: arbitrates two requesters onto one shared combinational ALU, one operation in flight.
// Latency: accept at cycle T -> response valid at T+2; next accept no earlier than T+3.
// Backpressure: a response holds until its rsp_ready; requesters see ready only while IDLE.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   reqN_valid/ready           request handshake for requester N (N = 0, 1)
//   reqN_x/y/funct3/funct7     operands and operation of requester N
//   rspN_valid/ready/data      response handshake and result for requester N
//   alu_x/y/funct3/funct7      registered operation driven to the shared ALU
//   alu_out                    combinational result returned by the shared ALU
//   busy                       high whenever an operation is in flight
module alu_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic [2:0]  req0_funct3,
  input  logic [6:0]  req0_funct7,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic [2:0]  req1_funct3,
  input  logic [6:0]  req1_funct7,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  input  logic        rsp1_ready,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  input  logic [31:0] alu_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q;
  logic        last_grant_q;   // requester served by the most recent completed operation
  logic        gnt_idx_q;      // requester owning the operation in flight
  logic        busy_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [2:0]  funct3_q;
  logic [6:0]  funct7_q;
  logic [31:0] result_q;

  logic gnt0;
  logic gnt1;
  logic accept;
  logic rsp_hs;

  // Requester 0 wins unless requester 1 also asks and round-robin says it is
  // requester 1's turn (requester 0 was served last).
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    gnt0 = req0_valid && (!req1_valid || (ROUND_ROBIN == 0) || last_grant_q);
    gnt1 = req1_valid && !gnt0;
  end

  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_hs     = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_idx_q    <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      funct3_q     <= '0;
      funct7_q     <= '0;
      result_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // req1_ready alone identifies the winner since at most one ready is high.
            x_q       <= req1_ready ? req1_x      : req0_x;
            y_q       <= req1_ready ? req1_y      : req0_y;
            funct3_q  <= req1_ready ? req1_funct3 : req0_funct3;
            funct7_q  <= req1_ready ? req1_funct7 : req0_funct7;
            gnt_idx_q <= req1_ready;
            busy_q    <= 1'b1;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= alu_out;
          rsp0_valid_q <= !gnt_idx_q;
          rsp1_valid_q <= gnt_idx_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= gnt_idx_q;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_x      = x_q;
  assign alu_y      = y_q;
  assign alu_funct3 = funct3_q;
  assign alu_funct7 = funct7_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority instance
// share the same request stimulus, each with its own ALU model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic [2:0]  req0_funct3, req1_funct3;
  logic [6:0]  req0_funct7, req1_funct7;
  logic        rsp0_ready, rsp1_ready;

  // round-robin instance
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp0_data, rsp1_data, alu_x, alu_y, alu_out;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;

  // fixed-priority instance
  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
  logic [31:0] fp_rsp0_data, fp_rsp1_data, fp_alu_x, fp_alu_y, fp_alu_out;
  logic [2:0]  fp_alu_funct3;
  logic [6:0]  fp_alu_funct7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0:    alu_model = (f7 != 7'd0) ? x - y : x + y;
      3'd4:    alu_model = x ^ y;
      3'd6:    alu_model = x | y;
      3'd7:    alu_model = x & y;
      default: alu_model = 32'd0;
    endcase
  endfunction

  assign alu_out    = alu_model(alu_x, alu_y, alu_funct3, alu_funct7);
  assign fp_alu_out = alu_model(fp_alu_x, fp_alu_y, fp_alu_funct3, fp_alu_funct7);

  alu_arbiter #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .alu_x(alu_x), .alu_y(alu_y), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_out(alu_out), .busy(busy)
  );

  alu_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
    .rsp0_valid(fp_rsp0_valid), .rsp0_data(fp_rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(fp_rsp1_valid), .rsp1_data(fp_rsp1_data), .rsp1_ready(rsp1_ready),
    .alu_x(fp_alu_x), .alu_y(fp_alu_y), .alu_funct3(fp_alu_funct3), .alu_funct7(fp_alu_funct7),
    .alu_out(fp_alu_out), .busy(fp_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req0_funct3 = '0; req0_funct7 = '0;
    req1_x = '0; req1_y = '0; req1_funct3 = '0; req1_funct7 = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_alu_x", alu_x, 0);
    check("rst_alu_y", alu_y, 0);
    check("rst_rsp0_data", rsp0_data, 0);
    check("rst_req0_ready_novalid", req0_ready, 0);

    // 5 + 3 from requester 0, response two cycles after accept
    req0_valid = 1'b1; req0_x = 32'd5; req0_y = 32'd3; req0_funct3 = 3'd0; req0_funct7 = 7'd0;
    #1;
    check("add_req0_ready", req0_ready, 1);
    check("add_req1_ready", req1_ready, 0);
    step();                       // T+1 : EXEC
    req0_valid = 1'b0;
    #1;
    check("add_exec_busy", busy, 1);
    check("add_exec_rsp0_valid", rsp0_valid, 0);
    check("add_exec_alu_x", alu_x, 5);
    check("add_exec_req0_ready", req0_ready, 0);
    step();                       // T+2 : RESP
    check("add_rsp0_valid", rsp0_valid, 1);
    check("add_rsp0_data", rsp0_data, 8);
    check("add_rsp1_valid", rsp1_valid, 0);
    step();                       // handshake done -> IDLE
    check("add_idle_busy", busy, 0);
    check("add_idle_rsp0_valid", rsp0_valid, 0);

    // 3 - 5 wraps
    req0_valid = 1'b1; req0_x = 32'd3; req0_y = 32'd5; req0_funct7 = 7'h20;
    step();
    req0_valid = 1'b0;
    step();
    check("sub_rsp0_valid", rsp0_valid, 1);
    check("sub_rsp0_data", rsp0_data, 32'hFFFF_FFFE);
    step();

    // Requester 1 alone, funct3 passed through (xor)
    req1_valid = 1'b1; req1_x = 32'h0000_F0F0; req1_y = 32'h0000_0FF0; req1_funct3 = 3'd4; req1_funct7 = 7'd0;
    #1;
    check("xor_req1_ready", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    #1;
    check("xor_alu_funct3", alu_funct3, 4);
    step();
    check("xor_rsp1_valid", rsp1_valid, 1);
    check("xor_rsp1_data", rsp1_data, 32'h0000_FF00);
    check("xor_rsp0_valid", rsp0_valid, 0);
    step();

    // Both requesters valid continuously: RR alternates 0,1,0,1; FP always 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_x = 32'd10;  req0_y = 32'd1; req0_funct3 = 3'd0; req0_funct7 = 7'd0;
    req1_valid = 1'b1; req1_x = 32'd100; req1_y = 32'd7; req1_funct3 = 3'd0; req1_funct7 = 7'h20;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr%0d_req0_ready", k), req0_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_req1_ready", k), req1_ready, (k % 2 == 1) ? 1 : 0);
      check($sformatf("fp%0d_accept_req1_ready", k), fp_req1_ready, 0);
      check($sformatf("fp%0d_accept_req0_ready", k), fp_req0_ready, 1);
      step();
      check($sformatf("rr%0d_exec_busy", k), busy, 1);
      check($sformatf("fp%0d_exec_req1_ready", k), fp_req1_ready, 0);
      step();
      check($sformatf("rr%0d_rsp0_valid", k), rsp0_valid, (k % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_rsp1_valid", k), rsp1_valid, (k % 2 == 1) ? 1 : 0);
      check($sformatf("rr%0d_rsp_data", k), (k % 2 == 0) ? rsp0_data : rsp1_data,
            (k % 2 == 0) ? 32'd11 : 32'd93);
      check($sformatf("fp%0d_rsp0_data", k), fp_rsp0_data, 11);
      check($sformatf("fp%0d_rsp1_valid", k), fp_rsp1_valid, 0);
      check($sformatf("fp%0d_resp_req1_ready", k), fp_req1_ready, 0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Response stall: everything holds while rsp0_ready is low
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 32'd7; req0_y = 32'd9; req0_funct3 = 3'd0; req0_funct7 = 7'd0;
    req1_valid = 1'b1;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_rsp0_valid", k), rsp0_valid, 1);
      check($sformatf("stall%0d_rsp0_data", k), rsp0_data, 16);
      check($sformatf("stall%0d_alu_x", k), alu_x, 7);
      check($sformatf("stall%0d_alu_y", k), alu_y, 9);
      check($sformatf("stall%0d_req0_ready", k), req0_ready, 0);
      check($sformatf("stall%0d_req1_ready", k), req1_ready, 0);
      check($sformatf("stall%0d_busy", k), busy, 1);
      step();
    end
    rsp0_ready = 1'b1;
    step();
    check("stall_done_busy", busy, 0);
    check("stall_done_req1_ready", req1_ready, 1);
    check("stall_done_req0_ready", req0_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Withdrawn request: no grant, tie-break state unchanged
    rst = 1'b1;
    step();
    rst = 1'b0;
    req1_valid = 1'b1;
    #1;
    check("withdraw_req1_ready", req1_ready, 1);
    req1_valid = 1'b0;
    step();
    check("withdraw_busy", busy, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("withdraw_tie_req0_ready", req0_ready, 1);
    check("withdraw_tie_req1_ready", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset during EXEC aborts the operation
    req0_valid = 1'b1; req0_x = 32'd20; req0_y = 32'd22;
    step();
    req0_valid = 1'b0;
    #1;
    check("abort_exec_busy", busy, 1);
    check("abort_exec_alu_x", alu_x, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rsp0_valid", rsp0_valid, 0);
    check("abort_rsp1_valid", rsp1_valid, 0);
    check("abort_alu_x", alu_x, 0);
    check("abort_alu_y", alu_y, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("abort_after%0d_rsp0_valid", k), rsp0_valid, 0);
      check($sformatf("abort_after%0d_busy", k), busy, 0);
    end

    // Reset wins over a simultaneous accept
    req0_valid = 1'b1;
    rst = 1'b1;
    step();
    check("rst_vs_accept_busy", busy, 0);
    rst = 1'b0;
    req0_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
